// File: rtl/seq_mult_unit_if.sv
// seq_mult_unit_if: Start/Busy/Done handshake and operand/product bus between CPU control and the multiplier.
//   master (CPU control): drives Start, Signed, A, B; observes Busy, Done, Hi, Lo
//   slave  (multiplier) : observes Start, Signed, A, B; drives Busy, Done, Hi, Lo
interface seq_mult_unit_if #(parameter int WIDTH = 32);
    logic             Start;
    logic             Signed;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Hi;
    logic [WIDTH-1:0] Lo;
    modport master (output Start, Signed, A, B, input Busy, Done, Hi, Lo);
    modport slave  (input Start, Signed, A, B, output Busy, Done, Hi, Lo);
endinterface

// File: rtl/seq_mult_unit.sv
// seq_mult_unit: iterative shift-add multiplier for MIPS mult/multu, one partial product per clock.
//   Clk   : clock, rising edge
//   Reset : asynchronous, active-low reset
//   bus   : seq_mult_unit_if.slave
//           Start/Signed/A/B in (sampled in IDLE only), Busy/Done/Hi/Lo out
//   Optional feature: define SEQ_MULT_EARLY_EXIT_EN to finish as soon as the
//   remaining multiplier bits are all zero (same result, shorter latency).
module seq_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic           Clk,
    input  logic           Reset,
    seq_mult_unit_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [CW-1:0]      count_q, count_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   abs_a, abs_b;

    // Operands are multiplied as magnitudes; the sign is reapplied at the end.
    // The most negative value negates to itself, which read as unsigned is the
    // correct magnitude.
    assign abs_a = (bus.Signed && bus.A[WIDTH-1]) ? -bus.A : bus.A;
    assign abs_b = (bus.Signed && bus.B[WIDTH-1]) ? -bus.B : bus.B;

    always_comb begin
        state_d  = state_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        hi_d     = hi_q;
        lo_d     = lo_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        prod_d   = prod_q;
        count_d  = count_q;
        neg_d    = neg_q;
        case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    mcand_d  = {{WIDTH{1'b0}}, abs_a};
                    mplier_d = abs_b;
                    neg_d    = bus.Signed & (bus.A[WIDTH-1] ^ bus.B[WIDTH-1]);
                    prod_d   = '0;
                    count_d  = '0;
                    busy_d   = 1'b1;
`ifdef SEQ_MULT_EARLY_EXIT_EN
                    state_d  = (abs_b == '0) ? FIN : RUN;
`else
                    state_d  = RUN;
`endif
                end
            end
            RUN: begin
                prod_d   = mplier_q[0] ? prod_q + mcand_q : prod_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
`ifdef SEQ_MULT_EARLY_EXIT_EN
                state_d  = (count_d == CW'(WIDTH) || mplier_d == '0) ? FIN : RUN;
`else
                state_d  = (count_d == CW'(WIDTH)) ? FIN : RUN;
`endif
            end
            FIN: begin
                {hi_d, lo_d} = neg_q ? -prod_q : prod_q;
                done_d       = 1'b1;
                busy_d       = 1'b0;
                state_d      = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            count_q  <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            prod_q   <= prod_d;
            count_q  <= count_d;
            neg_q    <= neg_d;
        end
    end

    assign bus.Busy = busy_q;
    assign bus.Done = done_q;
    assign bus.Hi   = hi_q;
    assign bus.Lo   = lo_q;
endmodule

// File: doc/seq_mult_unit.md
Name: seq_mult_unit

Overview:
- Iterative shift-add multiplier sequencer for the MIPS mult/multu path.
- Accepts two WIDTH-bit operands on a Start pulse and iterates one partial product per clock.
- Produces a 2*WIDTH-bit product into Hi/Lo registers, which are consumed by the HI/LO register stage downstream.
- Start/Busy/Done handshake toward the CPU control unit.

Parameters:
- WIDTH, 32, operand width in bits; product is 2*WIDTH bits.

Ports:
- Clk  input  1  clock; all state updates on the rising edge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  one-cycle request; sampled only in IDLE.
- Signed  input  1  1 = mult (two's complement), 0 = multu; sampled with Start.
- A  input  WIDTH  multiplicand; sampled with Start.
- B  input  WIDTH  multiplier; sampled with Start.
- Busy  output  1  high from the edge that accepts Start until the edge that asserts Done.
- Done  output  1  one-cycle pulse; Hi/Lo are valid and new while it is high.
- Hi  output  WIDTH  upper half of the product; holds until the next completion.
- Lo  output  WIDTH  lower half of the product; holds until the next completion.

Behaviour:
- Reset: Reset low forces, immediately and asynchronously:
  - state=IDLE, Busy=0, Done=0, Hi=0, Lo=0;
  - internal Mcand, Mplier, Prod, Count, NegFlag all 0.
- Reset low mid-operation aborts the operation; no Done is produced afterward.
- States: IDLE, RUN, FIN.
- IDLE:
  - Done=0, except during the cycle right after a FIN edge.
  - Start=1 at an edge (E0) accepts the operation:
    - Mcand = zero-extended |A| (2*WIDTH bits); Mplier = |B|.
    - |x| = two's-complement negation if Signed && x[WIDTH-1], otherwise x.
    - NegFlag = Signed & (A[msb] ^ B[msb]); Prod=0; Count=0; Busy=1.
    - Go to RUN.
- RUN, each edge (one iteration):
  - if Mplier[0]: Prod += Mcand (2*WIDTH-bit add, no overflow possible);
  - Mcand <<= 1; Mplier >>= 1 (logical); Count += 1.
  - Go to FIN after the iteration where Count reaches WIDTH.
  - Base latency: E0 accept, E1..E32 iterate, E33 completes (WIDTH=32). Busy is high for 33 cycles; Done is high in the cycle after E33.
- FIN, at one edge:
  - {Hi,Lo} = NegFlag ? -Prod : Prod (2*WIDTH-bit two's complement).
  - Done=1 for exactly one cycle; Busy=0; go to IDLE.
- Back-to-back: Start during the Done cycle is accepted (state is already IDLE).
- Start while Busy is ignored; operands are not re-sampled.
- Start held high for several cycles: only the first edge in IDLE is accepted; a second operation starts at the first IDLE edge where Start is still high.
- Signed boundary: |0x80000000| = 0x80000000 is treated as unsigned; the product is exact for all inputs.
- Operands may change freely after the accepting edge.
- Count width: clog2(WIDTH)+1 bits.

Optional Feature:
- Macro: SEQ_MULT_EARLY_EXIT_EN
- Defined:
  - RUN goes to FIN as soon as the post-shift Mplier == 0, even if Count < WIDTH.
  - If |B| == 0 at accept, E0 goes straight to FIN. Completion is then at E1, and Busy is high for 1 cycle.
  - Results are identical to the base behaviour; only latency changes.
- Not defined: always WIDTH iterations; fixed latency as above.

Test Plan:
- multu 3*5, macro off: Start at E0 -> Busy=1 for E0..E32; Done=1 after E33 with Hi=0x00000000, Lo=0x0000000F.
- multu 0xFFFFFFFF*0xFFFFFFFF -> Hi=0xFFFFFFFE, Lo=0x00000001.
- mult -7*3 -> Hi=0xFFFFFFFF, Lo=0xFFFFFFEB.
- mult 0x80000000*0x80000000 -> Hi=0x40000000, Lo=0x00000000.
- Robustness sequence:
  - Start pulse at E5 with different operands while Busy -> ignored; the first result is unchanged.
  - Reset low at E10 -> Busy=0, Hi=Lo=0 immediately; no Done afterward.
- Macro on:
  - 3*5 -> iterations at E1..E3, Done after E4, Lo=15.
  - 7*0 -> Done after E1, Hi=Lo=0.
